cpu_sequencer: RTL and testbench

- Multi-cycle control unit for the lab CPU.
- Fetches 32-bit instructions from instruction memory over a req/ack handshake and holds each one in an instruction register, which drives the decoder.
- Sequences the ALU-latch and register-file write strobes, and advances the PC.
- Detects HALT and NOP opcodes in instruction[31:16], and flags a fetch timeout when memory does not respond.

---
 rtl/cpu_sequencer.sv | 139 +++++++++++++
 tb/tb_cpu_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit for the lab CPU: fetches instructions over a req/ack
// handshake, sequences ALU-latch and register-file write strobes, and advances the PC.
module cpu_sequencer #(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned       PC_STEP     = 4,
    parameter logic [15:0]       NOP_OPCODE  = 16'h0000,
    parameter logic [15:0]       HALT_OPCODE = 16'hFFFF,
    parameter int unsigned       TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction,
    output logic              alu_en,
    output logic              rf_we,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr_count,
    output logic              halted,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT,
        S_ERROR
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [7:0]        tmo_q, tmo_d;
    logic              req_q, alu_q, we_q, halt_q, err_q;

    logic [ADDR_W-1:0] pc_next;
    logic [15:0]       opcode;

    // PC wraps silently at 2^ADDR_W by plain truncation.
    assign pc_next = pc_q + ADDR_W'(PC_STEP);
    assign opcode  = instr_q[31:16];

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                // An ack in the last permitted cycle takes priority over the timeout.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    tmo_d   = '0;
                    state_d = S_DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (opcode == HALT_OPCODE) begin
                    state_d = S_HALT;
                end else if (opcode == NOP_OPCODE) begin
                    pc_d    = pc_next;
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                pc_d    = pc_next;
                cnt_d   = cnt_q + 32'd1;
                state_d = S_FETCH;
            end
            S_HALT, S_ERROR: state_d = state_q;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order in the block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            req_q   <= 1'b0;
            alu_q   <= 1'b0;
            we_q    <= 1'b0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            // Strobes are decoded from the next state so they line up with it.
            req_q   <= (state_d == S_FETCH);
            alu_q   <= (state_d == S_EXEC);
            we_q    <= (state_d == S_WB);
            halt_q  <= (state_d == S_HALT);
            err_q   <= (state_d == S_ERROR);
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign instr_count = cnt_q;
    assign alu_en      = alu_q;
    assign rf_we       = we_q;
    assign halted      = halt_q;
    assign error       = err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a memory responder feeds programs and a
// program-level model predicts the event stream the monitor observes.
module tb_cpu_sequencer;

    localparam int          TMO    = 15;
    localparam logic [31:0] HALT_W = 32'hFFFF_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req, alu_en, rf_we, halted, error;
    logic [31:0] imem_addr, instruction, pc, instr_count;

    logic        start_w = 1'b0;
    logic        ack_w = 1'b0;
    logic [31:0] rdata_w = '0;
    logic        req_w, alu_w, we_w, halted_w, error_w;
    logic [31:0] addr_w, instr_w, pc_w, count_w;

    cpu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instruction(instruction), .alu_en(alu_en),
        .rf_we(rf_we), .pc(pc), .instr_count(instr_count), .halted(halted),
        .error(error)
    );

    cpu_sequencer #(.RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w),
        .imem_req(req_w), .imem_addr(addr_w), .imem_ack(ack_w),
        .imem_rdata(rdata_w), .instruction(instr_w), .alu_en(alu_w),
        .rf_we(we_w), .pc(pc_w), .instr_count(count_w), .halted(halted_w),
        .error(error_w)
    );

    typedef enum int {EV_FETCH, EV_ALU, EV_WB, EV_HALT, EV_ERR} ev_e;
    typedef struct {
        ev_e         kind;
        logic [31:0] addr;
        logic [31:0] ins;
        logic [31:0] cnt;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          dly_q[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] m_pc = '0;
    logic [31:0] m_cnt = '0;
    bit          stray = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          cyc_n = 0;

    always @(posedge clk) cyc_n++;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        return mem.exists(a) ? mem[a] : HALT_W;
    endfunction

    task automatic push(ev_e k, logic [31:0] a, logic [31:0] ins, logic [31:0] cnt, int c);
        exp_t e;
        e.kind = k; e.addr = a; e.ins = ins; e.cnt = cnt; e.cyc = c;
        sb.push_back(e);
    endtask

    // Program-level model: given the word at the model's own PC, predict what follows.
    task automatic model_retire(logic [31:0] w, int c);
        if (w[31:16] == 16'hFFFF) begin
            push(EV_HALT, m_pc, w, m_cnt, c + 2);
        end else if (w[31:16] == 16'h0000) begin
            m_cnt = m_cnt + 1;
            m_pc  = m_pc + 4;
            push(EV_FETCH, m_pc, '0, m_cnt, c + 2);
        end else begin
            push(EV_ALU, m_pc, w, m_cnt, c + 2);
            push(EV_WB,  m_pc, w, m_cnt, c + 3);
            m_cnt = m_cnt + 1;
            m_pc  = m_pc + 4;
            push(EV_FETCH, m_pc, '0, m_cnt, c + 4);
        end
    endtask

    // Memory responder: acks after a per-fetch delay, junk data otherwise.
    int          rcyc = 0;
    int          rd = 0;
    logic [31:0] r_addr0 = '0;
    logic [31:0] r_ins0 = '0;
    always @(negedge clk) begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (stray) begin
            imem_ack = 1'b1;
        end else if (rst_n && imem_req) begin
            if (rcyc == 0) begin
                rd      = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
                r_addr0 = imem_addr;
                r_ins0  = instruction;
                if (rd >= TMO) push(EV_ERR, '0, '0, m_cnt, cyc_n + TMO);
            end else begin
                check("addr_stable", imem_addr, r_addr0);
                check("ir_hold", instruction, r_ins0);
            end
            if (rcyc == rd) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_rd(imem_addr);
                model_retire(mem_rd(m_pc), cyc_n);
            end
            rcyc++;
        end else begin
            rcyc = 0;
        end
    end

    always @(negedge clk) begin
        ack_w   = req_w;
        rdata_w = (addr_w == WRAP_PC) ? 32'h0005_0001 : HALT_W;
    end

    task automatic take(ev_e k);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got event %s, none expected (t=%0t)", k.name(), $time);
            return;
        end
        e = sb.pop_front();
        check("ev_kind", 32'(k), 32'(e.kind));
        check("ev_cycle", 32'(cyc_n), 32'(e.cyc));
        check("ev_count", instr_count, e.cnt);
        case (k)
            EV_FETCH: check("fetch_addr", imem_addr, e.addr);
            EV_ALU, EV_WB: begin
                check("ex_pc", pc, e.addr);
                check("ex_ir", instruction, e.ins);
            end
            EV_HALT: check("halt_pc", pc, e.addr);
            EV_ERR:  check("err_req", 32'(imem_req), 32'd0);
            default: ;
        endcase
    endtask

    logic req_p = 1'b0, halt_p = 1'b0, err_p = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            check("alu_rf_excl", 32'(alu_en & rf_we), 32'd0);
            check("addr_eq_pc", imem_addr, pc);
            if (imem_req && !req_p) take(EV_FETCH);
            if (alu_en) take(EV_ALU);
            if (rf_we) take(EV_WB);
            if (halted && !halt_p) take(EV_HALT);
            if (error && !err_p) take(EV_ERR);
        end
        req_p  = imem_req;
        halt_p = halted;
        err_p  = error;
    end

    function automatic logic sel(int w);
        case (w)
            0: return halted;
            1: return error;
            2: return alu_en;
            3: return we_w;
            4: return halted_w;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(string name, int w, int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (sel(w)) return;
        end
        total++;
        bad++;
        $display("FAIL %s: timed out after %0d cycles", name, lim);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; start_w = 1'b0; stray = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete(); dly_q.delete(); mem.delete();
        m_pc = '0; m_cnt = '0;
        rst_n = 1'b1;
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        push(EV_FETCH, m_pc, '0, m_cnt, cyc_n + 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drained(string name);
        @(negedge clk);
        check(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] w;

        // Reset state
        do_reset();
        check("rst_req", 32'(imem_req), 0);
        check("rst_pc", pc, 0);
        check("rst_ir", instruction, 0);
        check("rst_cnt", instr_count, 0);
        check("rst_flags", {28'd0, alu_en, rf_we, halted, error}, 0);
        check("rst_pc_w", pc_w, WRAP_PC);

        // Single non-NOP instruction, immediate ack
        mem[0] = 32'h0001_0000; mem[4] = HALT_W;
        dly_q = '{0, 0};
        kick();
        wait_for("t1_halt", 0, 40);
        check("t1_pc", pc, 4);
        check("t1_cnt", instr_count, 1);
        drained("t1_drained");

        // Ack delayed three cycles
        do_reset();
        mem[0] = 32'h1234_5678; mem[4] = HALT_W;
        dly_q = '{3, 0};
        kick();
        wait_for("t2_halt", 0, 40);
        check("t2_pc", pc, 4);
        drained("t2_drained");

        // NOP, ALU op, HALT; start afterwards is ignored
        do_reset();
        mem[0] = 32'h0000_0000; mem[4] = 32'h0002_1234; mem[8] = HALT_W;
        kick();
        wait_for("t3_halt", 0, 40);
        repeat (3) begin
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        @(negedge clk);
        check("t3_pc", pc, 8);
        check("t3_cnt", instr_count, 2);
        check("t3_halted", 32'(halted), 1);
        check("t3_req", 32'(imem_req), 0);
        drained("t3_drained");

        // Fetch timeout, then ack on the last allowed cycle
        do_reset();
        mem[0] = 32'h0007_0000;
        dly_q = '{1000};
        kick();
        wait_for("t4_error", 1, 40);
        check("t4_error", 32'(error), 1);
        check("t4_req", 32'(imem_req), 0);
        drained("t4_drained");
        do_reset();
        mem[0] = 32'h0007_0000; mem[4] = HALT_W;
        dly_q = '{TMO - 1, 0};
        kick();
        wait_for("t4b_halt", 0, 60);
        check("t4b_error", 32'(error), 0);
        check("t4b_cnt", instr_count, 1);
        drained("t4b_drained");

        // Reset in EXEC, then stray acks while idle
        do_reset();
        mem[0] = 32'h0009_0000; mem[4] = HALT_W;
        kick();
        wait_for("t5_exec", 2, 20);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check("t5_strobes", {30'd0, alu_en, rf_we}, 0);
        check("t5_pc", pc, 0);
        check("t5_cnt", instr_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        check("t5_idle_req", 32'(imem_req), 0);
        check("t5_idle_ir", instruction, 0);
        check("t5_idle_pc", pc, 0);

        // PC wrap from the top of the address space
        do_reset();
        @(negedge clk) start_w = 1'b1;
        @(negedge clk) start_w = 1'b0;
        wait_for("t6_wb", 3, 20);
        @(negedge clk);
        check("t6_pc_wrap", pc_w, 0);
        check("t6_addr", addr_w, 0);
        check("t6_req", 32'(req_w), 1);
        wait_for("t6_halt", 4, 20);
        check("t6_cnt", count_w, 1);

        // Random programs with random ack delays
        for (int it = 0; it < 25; it++) begin
            do_reset();
            n = $urandom_range(1, 10);
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                if ($urandom_range(0, 3) == 0) w[31:16] = 16'h0000;
                else w[31:16] = 16'($urandom_range(1, 16'hFFFE));
                mem[32'(4 * k)] = w;
                dly_q.push_back($urandom_range(0, 3));
            end
            mem[32'(4 * n)] = HALT_W;
            dly_q.push_back($urandom_range(0, 3));
            kick();
            wait_for("rnd_halt", 0, 300);
            check("rnd_pc", pc, 32'(4 * n));
            check("rnd_cnt", instr_count, 32'(n));
            drained("rnd_drained");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
